fm6126_scan: RTL and testbench

FM6126_SCAN -- requirements
Module: fm6126_scan

---
 rtl/fm6126_scan_pkg.sv | 22 ++
 rtl/fm6126_row_timer.sv | 35 +++
 rtl/fm6126_scan.sv | 200 ++++++++++++++++++++
 tb/tb_fm6126_scan.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm6126_scan_pkg.sv
// Shared types and constants for the FM6126 scan engine.
// Optional build macro: FM6126_GHOST_GUARD_EN (split guard blanking).
package fm6126_scan_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SHIFT   = 3'd1;
  localparam state_t ST_LATCH   = 3'd2;
  localparam state_t ST_BLANK   = 3'd3;
  localparam state_t ST_DISPLAY = 3'd4;

  localparam logic OE_OFF    = 1'b1;
  localparam logic LATCH_OFF = 1'b0;

  localparam int LATCH_LEN = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fm6126_row_timer.sv
// Loadable down-counter timing the latch, blank and display phases.
// done is high in the last cycle of a loaded interval.
module fm6126_row_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val - W'(1);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - W'(1);
    end
  end

  assign done = busy && (cnt == '0);

endmodule

// File: rtl/fm6126_scan.sv
// FM6126 HUB75 row scanner: shift, latch, blank, display per row pair.
// Build macro FM6126_GHOST_GUARD_EN adds guard blanking around row change.
module fm6126_scan
  import fm6126_scan_pkg::*;
#(
  parameter int PIXEL_WIDTH   = 64,
  parameter int ROW_BITS      = 4,
  parameter int BRIGHT_CYCLES = 256,
  parameter int GUARD_CYCLES  = 2
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic                           mask_en,
  output logic [$clog2(PIXEL_WIDTH)-1:0] column_address,
  input  logic [2:0]                     pixel_rgb1,
  input  logic [2:0]                     pixel_rgb2,
  output logic                           clk_pixel_out,
  output logic [2:0]                     rgb1_out,
  output logic [2:0]                     rgb2_out,
  output logic                           latch_out,
  output logic                           output_enable_out,
  output logic [ROW_BITS-1:0]            row_address_out,
  output logic                           frame_start
);

  localparam int CW = $clog2(PIXEL_WIDTH);
  localparam int TMAX = max_int(BRIGHT_CYCLES,
                        max_int(LATCH_LEN, GUARD_CYCLES));
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(PIXEL_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = '1;
`ifdef FM6126_GHOST_GUARD_EN
  localparam int BLANK_STEP = GUARD_CYCLES;
`else
  localparam int BLANK_STEP = 1;
`endif

  state_t              state, state_nx;
  logic                phase;
  logic [CW-1:0]       col_cnt;
  logic [ROW_BITS-1:0] row_cnt;
  logic                arm_q;
  logic                t_done, t_load;
  logic [TW-1:0]       t_val;
  logic                col_inc, row_inc, row_upd, rgb_load;
`ifdef FM6126_GHOST_GUARD_EN
  logic                blank_half;
  logic                blank_flip;
`endif

  fm6126_row_timer #(.W(TW)) u_timer (
    .clk      (clk_in),
    .rst_n    (reset),
    .clear    (mask_en),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_comb begin
    state_nx = state;
    t_load   = 1'b0;
    t_val    = '0;
    col_inc  = 1'b0;
    row_inc  = 1'b0;
    row_upd  = 1'b0;
    rgb_load = 1'b0;
`ifdef FM6126_GHOST_GUARD_EN
    blank_flip = 1'b0;
`endif
    if (mask_en) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (arm_q) begin
            state_nx = ST_SHIFT;
            rgb_load = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (phase) begin
            if (col_cnt == COL_LAST) begin
              state_nx = ST_LATCH;
              t_load   = 1'b1;
              t_val    = TW'(LATCH_LEN);
            end else begin
              col_inc  = 1'b1;
              rgb_load = 1'b1;
            end
          end
        end
        ST_LATCH: begin
          if (t_done) begin
            state_nx = ST_BLANK;
            t_load   = 1'b1;
            t_val    = TW'(BLANK_STEP);
`ifndef FM6126_GHOST_GUARD_EN
            row_upd  = 1'b1;
`endif
          end
        end
        ST_BLANK: begin
          if (t_done) begin
`ifdef FM6126_GHOST_GUARD_EN
            if (!blank_half) begin
              row_upd    = 1'b1;
              blank_flip = 1'b1;
              t_load     = 1'b1;
              t_val      = TW'(GUARD_CYCLES);
            end else begin
              state_nx = ST_DISPLAY;
              t_load   = 1'b1;
              t_val    = TW'(BRIGHT_CYCLES);
            end
`else
            state_nx = ST_DISPLAY;
            t_load   = 1'b1;
            t_val    = TW'(BRIGHT_CYCLES);
`endif
          end
        end
        ST_DISPLAY: begin
          if (t_done) begin
            state_nx = ST_SHIFT;
            row_inc  = 1'b1;
            rgb_load = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      arm_q           <= 1'b0;
      phase           <= 1'b0;
      col_cnt         <= '0;
      row_cnt         <= '0;
      row_address_out <= '0;
      rgb1_out        <= '0;
      rgb2_out        <= '0;
`ifdef FM6126_GHOST_GUARD_EN
      blank_half      <= 1'b0;
`endif
    end else begin
      arm_q <= 1'b1;
      state <= state_nx;
      if (mask_en) begin
        phase           <= 1'b0;
        col_cnt         <= '0;
        row_cnt         <= '0;
        row_address_out <= '0;
        rgb1_out        <= '0;
        rgb2_out        <= '0;
`ifdef FM6126_GHOST_GUARD_EN
        blank_half      <= 1'b0;
`endif
      end else begin
        phase <= (state == ST_SHIFT) ? ~phase : 1'b0;
        if (col_inc)
          col_cnt <= col_cnt + CW'(1);
        else if (state_nx != ST_SHIFT)
          col_cnt <= '0;
        if (row_inc)
          row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_BITS'(1);
        if (row_upd)
          row_address_out <= row_cnt;
        // rgb settles a full cycle before the shift clock rises
        if (rgb_load) begin
          rgb1_out <= pixel_rgb1;
          rgb2_out <= pixel_rgb2;
        end
`ifdef FM6126_GHOST_GUARD_EN
        if (blank_flip)
          blank_half <= 1'b1;
        else if (state_nx != ST_BLANK)
          blank_half <= 1'b0;
`endif
      end
    end
  end

  // prefetch: frame buffer returns data one cycle after the address
  always_comb begin
    column_address = '0;
    if (state == ST_SHIFT && col_cnt != COL_LAST)
      column_address = col_cnt + CW'(1);
  end

  assign clk_pixel_out     = (state == ST_SHIFT) && phase;
  assign latch_out         = (state == ST_LATCH) ? ~LATCH_OFF : LATCH_OFF;
  assign output_enable_out = (state == ST_DISPLAY) ? ~OE_OFF : OE_OFF;
  assign frame_start = !mask_en && (
    (state == ST_IDLE && arm_q) ||
    (state == ST_DISPLAY && t_done && row_cnt == ROW_LAST));

endmodule

// File: tb/tb_fm6126_scan.sv
// Scoreboard bench for fm6126_scan: row-level reference model vs monitor.
// Expected rows are queued by stimulus, popped by a negedge monitor.
module tb_fm6126_scan;

  localparam int PW = 64;
  localparam int RB = 4;
  localparam int BC = 256;
  localparam int GC = 2;
`ifdef FM6126_GHOST_GUARD_EN
  localparam int BLANK_EXP = 2 * GC;
  localparam int AFTER_EXP = GC;
`else
  localparam int BLANK_EXP = 1;
  localparam int AFTER_EXP = 1;
`endif
  localparam int PERIOD = 2 * PW + 2 + BLANK_EXP + BC;
  localparam int NROWS = 1 << RB;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       mask_en;
  logic [5:0] column_address;
  logic [2:0] pixel_rgb1, pixel_rgb2;
  logic       clk_pixel_out;
  logic [2:0] rgb1_out, rgb2_out;
  logic       latch_out, output_enable_out;
  logic [3:0] row_address_out;
  logic       frame_start;

  fm6126_scan #(
    .PIXEL_WIDTH(PW), .ROW_BITS(RB),
    .BRIGHT_CYCLES(BC), .GUARD_CYCLES(GC)
  ) dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .mask_en           (mask_en),
    .column_address    (column_address),
    .pixel_rgb1        (pixel_rgb1),
    .pixel_rgb2        (pixel_rgb2),
    .clk_pixel_out     (clk_pixel_out),
    .rgb1_out          (rgb1_out),
    .rgb2_out          (rgb2_out),
    .latch_out         (latch_out),
    .output_enable_out (output_enable_out),
    .row_address_out   (row_address_out),
    .frame_start       (frame_start)
  );

  always #5 clk_in = ~clk_in;

  // synchronous frame buffer: one cycle of read latency
  logic [2:0] lut1 [PW];
  logic [2:0] lut2 [PW];
  always @(posedge clk_in) begin
    pixel_rgb1 <= lut1[column_address];
    pixel_rgb2 <= lut2[column_address];
  end

  typedef struct {
    bit is_row;
    int k;
    int r1;
    int r2;
    int row;
    int fs;
    int period;
    int chg;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int rows_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void push_rows(input int n, input bit partial);
    exp_t e;
    int lim = partial ? n + 1 : n;
    for (int r = 0; r < lim; r++) begin
      for (int k = 0; k < PW; k++) begin
        e = '{0, k, int'(lut1[k]), int'(lut2[k]), 0, 0, 0, 0};
        q.push_back(e);
      end
      if (r < n) begin
        e = '{1, 0, 0, 0, r % NROWS, (r % NROWS == 0) ? 1 : 0,
              (r == 0) ? -1 : PERIOD, (r > 0) ? 1 : 0};
        q.push_back(e);
      end
    end
  endfunction

  // monitor state
  int  cyc = 0;
  int  rise_k, latch_len, oe_len, fs_cnt, fs_row, fs_cyc;
  int  rises_at_latch, last_latch, period, t_lfall, t_ofall, t_chg;
  bit  chg_seen;
  logic p_clk, p_latch, p_oe;
  logic [3:0] p_row;

  always @(negedge clk_in) begin
    exp_t it;
    cyc++;
    if (!reset || mask_en) begin
      rise_k = 0; latch_len = 0; oe_len = 0; fs_cnt = 0; fs_row = 0;
      rises_at_latch = 0; last_latch = -1; period = -1;
      chg_seen = 0; t_lfall = 0; t_ofall = 0; t_chg = 0; fs_cyc = 0;
    end else begin
      chk("latch_oe_excl", 32'(latch_out & ~output_enable_out), 0);
      if (row_address_out !== p_row) begin
        chk("row_chg_oe_high", 32'(output_enable_out), 1);
        chg_seen = 1;
        t_chg = cyc;
      end
      if (frame_start) begin
        fs_cnt++;
        fs_cyc = cyc;
      end
      if (clk_pixel_out && !p_clk) begin
        if (rise_k == 0 && fs_cnt > 0)
          chk("fs_to_first_rise", cyc - fs_cyc, 2);
        if (q.size() == 0) begin
          chk("pix_unexpected", q.size(), 1);
        end else begin
          it = q.pop_front();
          chk("pix_tag", it.is_row, 0);
          chk("pix_index", rise_k, it.k);
          chk("pix_rgb1", rgb1_out, it.r1);
          chk("pix_rgb2", rgb2_out, it.r2);
        end
        rise_k++;
      end
      if (latch_out) latch_len++;
      if (latch_out && !p_latch) begin
        period = (last_latch >= 0) ? cyc - last_latch : -1;
        last_latch = cyc;
        fs_row = fs_cnt;
        fs_cnt = 0;
        rises_at_latch = rise_k;
      end
      if (!latch_out && p_latch) t_lfall = cyc;
      if (!output_enable_out && p_oe) t_ofall = cyc;
      if (!output_enable_out) begin
        oe_len++;
        if (oe_len > 1) chk("row_stable_disp", row_address_out, p_row);
      end
      if (output_enable_out && !p_oe) begin
        if (q.size() == 0) begin
          chk("row_unexpected", q.size(), 1);
        end else begin
          it = q.pop_front();
          chk("row_tag", it.is_row, 1);
          chk("rises_before_latch", rises_at_latch, PW);
          chk("rises_total", rise_k, PW);
          chk("latch_len", latch_len, 2);
          chk("oe_low_len", oe_len, BC);
          chk("blank_len", t_ofall - t_lfall, BLANK_EXP);
          chk("row_addr", row_address_out, it.row);
          chk("frame_start_cnt", fs_row, it.fs);
          chk("row_changed", chg_seen, it.chg);
          if (chg_seen) chk("chg_to_oe", t_ofall - t_chg, AFTER_EXP);
          if (it.period >= 0) chk("row_period", period, it.period);
        end
        rows_seen++;
        rise_k = 0; latch_len = 0; oe_len = 0; chg_seen = 0;
      end
    end
    p_clk = clk_pixel_out;
    p_latch = latch_out;
    p_oe = output_enable_out;
    p_row = row_address_out;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_rows(input int target, input int budget);
    int i = 0;
    while (rows_seen < target && i < budget) begin
      cycles(1);
      i++;
    end
    chk("rows_done_in_time", 32'(rows_seen >= target), 1);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_pclk"}, clk_pixel_out, 0);
    chk({nm, "_latch"}, latch_out, 0);
    chk({nm, "_oe"}, output_enable_out, 1);
    chk({nm, "_rgb"}, {rgb1_out, rgb2_out}, 0);
    chk({nm, "_row"}, row_address_out, 0);
    chk({nm, "_col"}, column_address, 0);
  endtask

  task automatic rand_luts(input bit ramp);
    for (int k = 0; k < PW; k++) begin
      lut1[k] = ramp ? 3'(k % 8) : 3'($urandom_range(0, 7));
      lut2[k] = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base, n, i;
    reset = 1'b0;
    mask_en = 1'b0;
    rand_luts(0);
    cycles(3);
    chk_idle("reset");
    chk("reset_fs", frame_start, 0);

    // full frame plus wrap into a second frame
    push_rows(NROWS + 1, 1);
    reset = 1'b1;
    #1;
    chk("fs_before_sync", frame_start, 0);
    @(posedge clk_in);
    #1;
    chk("fs_after_sync", frame_start, 1);
    chk("pclk_after_sync", clk_pixel_out, 0);
    wait_rows(NROWS + 1, (NROWS + 2) * 400);
    cycles($urandom_range(0, 100));
    mask_en = 1'b1;
    q.delete();

    // 50-cycle mask hold, ramp data, stop during display of row 5
    rand_luts(1);
    cycles(50);
    chk_idle("mask_hold");
    chk("mask_hold_fs", frame_start, 0);
    base = rows_seen;
    push_rows(5, 1);
    mask_en = 1'b0;
    wait_rows(base + 5, 6 * 400);
    i = 0;
    while (!(row_address_out == 4'd5 && !output_enable_out) && i < 400) begin
      cycles(1);
      i++;
    end
    chk("row5_display_found", 32'(i < 400), 1);
    cycles($urandom_range(0, 200));
    chk("row5_still_display", output_enable_out, 0);
    mask_en = 1'b1;
    cycles(1);
    chk_idle("mask_in_display");
    chk("q_empty_after_row5", q.size(), 0);
    q.delete();

    // random restarts with partial rows cut off by mask
    for (int it = 0; it < 3; it++) begin
      rand_luts(0);
      cycles($urandom_range(1, 20));
      n = $urandom_range(1, 3);
      base = rows_seen;
      push_rows(n, 1);
      mask_en = 1'b0;
      wait_rows(base + n, (n + 1) * 400);
      cycles($urandom_range(0, 100));
      mask_en = 1'b1;
      q.delete();
    end
    cycles(2);
    chk_idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
